vga_char_buffer: RTL

Avalon-MM slave character buffer at the receiving end of the VGA character-write path. Accepts single-beat character writes and reads from on-chip masters such as the score display logic, stores one 8-bit character per cell of an 80×60 grid, and serves a dedicated scan-out read port to the VGA character renderer. After every reset it clears all cells to ASCII space (0x20) before accepting bus traffic.

---
 rtl/vga_char_buffer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vga_char_buffer.sv
// vga_char_buffer
//   Avalon-MM slave holding one 8-bit character per cell of a COLS x ROWS
//   text grid, plus a dedicated scan-out port for the VGA character renderer.
//   After every reset the whole grid is filled with BLANK_CHAR before the bus
//   side is allowed in.
//
// Ports
//   clk, reset_n        single clock, synchronous active-low reset
//   s_address[12:0]     {row[5:0], col[6:0]}
//   s_read, s_write     single-beat bus requests (write wins if both high)
//   s_writedata[15:0]   character in [7:0], [15:8] ignored
//   s_readdata[15:0]    {8'h00, char} in the cycle a read completes, else 0
//   s_waitrequest       combinational stall
//   scan_req/col/row    renderer fetch request (strict priority over the bus)
//   scan_valid/char     fetch result, one cycle after a granted request
//   ready               clear pass finished
//   state_export[1:0]   0 = CLEAR, 1 = IDLE, 2 = RD_WAIT
module vga_char_buffer #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 60,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [15:0] s_writedata,
  output logic [15:0] s_readdata,
  output logic        s_waitrequest,
  input  logic        scan_req,
  input  logic [6:0]  scan_col,
  input  logic [5:0]  scan_row,
  output logic        scan_valid,
  output logic [7:0]  scan_char,
  output logic        ready,
  output logic [1:0]  state_export
);

  localparam int unsigned CELLS    = COLS * ROWS;
  localparam logic [12:0] LAST_IDX = 13'(CELLS - 1);

  localparam logic [1:0] ST_CLEAR   = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  // Linear cell index y*COLS + x.
  function automatic logic [12:0] cell_index(input logic [6:0] x, input logic [5:0] y);
    return 13'({7'd0, y} * 13'(COLS)) + {6'd0, x};
  endfunction

  // Widened compares so that COLS = 128 / ROWS = 64 still work.
  function automatic logic cell_in_range(input logic [6:0] x, input logic [5:0] y);
    return ({1'b0, x} < 8'(COLS)) && ({1'b0, y} < 7'(ROWS));
  endfunction

  logic [7:0]  mem [0:CELLS-1];

  logic [1:0]  state_q, state_d;
  logic [12:0] clr_cnt_q, clr_cnt_d;
  logic        ready_q, ready_d;
  logic        scan_valid_q, scan_valid_d;
  logic [7:0]  scan_char_q, scan_char_d;
  logic [15:0] readdata_q, readdata_d;

  logic        ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        waitreq;

  logic [6:0]  bus_x;
  logic [5:0]  bus_y;
  logic        bus_in;
  logic [12:0] bus_idx;
  logic        scan_in;
  logic [12:0] scan_idx;
  logic        unused_bits;

  assign bus_x       = s_address[6:0];
  assign bus_y       = s_address[12:7];
  assign bus_in      = cell_in_range(bus_x, bus_y);
  assign bus_idx     = cell_index(bus_x, bus_y);
  assign scan_in     = cell_in_range(scan_col, scan_row);
  assign scan_idx    = cell_index(scan_col, scan_row);
  assign unused_bits = &{1'b0, s_writedata[15:8]};

  // ram_addr is only ever steered to an in-range cell, so this read is safe.
  assign ram_rdata = mem[ram_addr];

  // Arbitration, clear sequencing and next-state/output computation.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    ready_d      = ready_q;
    scan_valid_d = 1'b0;
    scan_char_d  = scan_char_q;
    readdata_d   = 16'h0000;
    ram_we       = 1'b0;
    ram_addr     = 13'd0;
    ram_wdata    = BLANK_CHAR;
    waitreq      = 1'b1;

    case (state_q)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt_q;
        // The renderer is answered with blanks without touching the RAM.
        if (scan_req) begin
          scan_valid_d = 1'b1;
          scan_char_d  = BLANK_CHAR;
        end else begin
          scan_valid_d = 1'b0;
        end
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          ready_d   = 1'b1;
          clr_cnt_d = 13'd0;
        end else begin
          clr_cnt_d = clr_cnt_q + 13'd1;
        end
      end

      ST_IDLE: begin
        if (scan_req) begin
          // Scan owns the port; any bus request waits this cycle.
          ram_addr     = scan_in ? scan_idx : 13'd0;
          scan_valid_d = 1'b1;
          scan_char_d  = scan_in ? ram_rdata : BLANK_CHAR;
          waitreq      = s_read | s_write;
        end else if (s_write) begin
          waitreq   = 1'b0;
          ram_we    = bus_in;
          ram_addr  = bus_in ? bus_idx : 13'd0;
          ram_wdata = s_writedata[7:0];
        end else if (s_read) begin
          waitreq    = 1'b1;
          ram_addr   = bus_in ? bus_idx : 13'd0;
          readdata_d = {8'h00, (bus_in ? ram_rdata : 8'h00)};
          state_d    = ST_RD_WAIT;
        end else begin
          waitreq = 1'b0;
        end
      end

      ST_RD_WAIT: begin
        // Read data is presented now; a scan_req here is not granted and
        // the renderer keeps it asserted into the next cycle.
        waitreq = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = 13'd0;
        ready_d   = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= 13'd0;
      ready_q      <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_char_q  <= 8'h00;
      readdata_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      ready_q      <= ready_d;
      scan_valid_q <= scan_valid_d;
      scan_char_q  <= scan_char_d;
      readdata_q   <= readdata_d;
    end
  end

  // Character RAM write port; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  assign s_readdata    = readdata_q;
  assign s_waitrequest = waitreq;
  assign scan_valid    = scan_valid_q;
  assign scan_char     = scan_char_q;
  assign ready         = ready_q;
  assign state_export  = state_q;

endmodule
